bus_tx: RTL and testbench



---
 rtl/bus_pkg.sv | 14 +
 rtl/bus_tx.sv | 95 +++++++++
 tb/tb_bus_tx.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// bus_pkg: shared definitions for the 8-bit Bus link.
// Used by the producer-side bus_tx. The receiver side imports the same package.
//   TxState_t : transmitter FSM state (IDLE, SEND)
//   BUS_W     : bus byte width
package bus_pkg;

    localparam int BUS_W = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } TxState_t;

endpackage

// File: rtl/bus_tx.sv
// bus_tx: word-to-byte transmitter for the 8-bit Bus link.
// Takes WIDTH-bit words on a valid/ready stream. Each word is sent least
// significant byte first. Receiver backpressure is honoured via IN_busStall.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   IN_valid       upstream word valid
//   IN_data        upstream word (WIDTH bits, multiple of 8, >= 8)
//   OUT_ready      combinational; a word is captured on edges where it is high
//   OUT_busData    current byte (registered)
//   OUT_busEnable  OUT_busData is valid (registered)
//   OUT_busLast    current byte ends its word (registered)
//   IN_busStall    receiver cannot take the byte this cycle
module bus_tx
    import bus_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             IN_valid,
    input  logic [WIDTH-1:0] IN_data,
    output logic             OUT_ready,
    output logic [BUS_W-1:0] OUT_busData,
    output logic             OUT_busEnable,
    output logic             OUT_busLast,
    input  logic             IN_busStall
);

    localparam int BYTES = WIDTH / BUS_W;
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

    TxState_t         state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [IDX_W-1:0] byte_idx_q, byte_idx_d;
    logic             last_q;
    logic             accept;

    assign last_q = (byte_idx_q == LAST_IDX);

    // Ready while idle, or on the final byte when it will actually leave this
    // edge, so the next word loads with no bubble. Held low during reset.
    assign OUT_ready = rst_n &&
                       ((state_q == IDLE) ||
                        ((state_q == SEND) && last_q && !IN_busStall));
    assign accept    = IN_valid && OUT_ready;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        byte_idx_d = byte_idx_q;
        case (state_q)
            IDLE: begin
                // Stall is irrelevant here; nothing is on the bus.
                if (accept) begin
                    shift_d    = IN_data;
                    byte_idx_d = '0;
                    state_d    = SEND;
                end
            end
            SEND: begin
                // Stalled cycles fall through and hold everything.
                if (!IN_busStall) begin
                    if (!last_q) begin
                        shift_d    = shift_q >> BUS_W;
                        byte_idx_d = byte_idx_q + IDX_W'(1);
                    end else if (accept) begin
                        shift_d    = IN_data;
                        byte_idx_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            byte_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            byte_idx_q <= byte_idx_d;
        end
    end

    assign OUT_busData   = shift_q[BUS_W-1:0];
    assign OUT_busEnable = (state_q == SEND);
    assign OUT_busLast   = (state_q == SEND) && last_q;

endmodule

// File: tb/tb_bus_tx.sv
// Directed bench for bus_tx: a WIDTH=32 instance and a WIDTH=8 instance.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_bus_tx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        v32 = 1'b0;
    logic [31:0] d32 = '0;
    logic        st32 = 1'b0;
    logic        rdy32;
    logic [7:0]  bd32;
    logic        en32, last32;

    logic        v8 = 1'b0;
    logic [7:0]  d8 = '0;
    logic        st8 = 1'b0;
    logic        rdy8;
    logic [7:0]  bd8;
    logic        en8, last8;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bus_tx #(.WIDTH(32)) u32 (
        .clk(clk), .rst_n(rst_n), .IN_valid(v32), .IN_data(d32),
        .OUT_ready(rdy32), .OUT_busData(bd32), .OUT_busEnable(en32),
        .OUT_busLast(last32), .IN_busStall(st32)
    );

    bus_tx #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .IN_valid(v8), .IN_data(d8),
        .OUT_ready(rdy8), .OUT_busData(bd8), .OUT_busEnable(en8),
        .OUT_busLast(last8), .IN_busStall(st8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Check the registered bus outputs plus ready of the 32-bit instance.
    task automatic bus32(input string tag, input logic en, input logic [7:0] d,
                         input logic last, input logic rdy);
        chk({tag, ".en"},   {31'd0, en32},   {31'd0, en});
        if (en) chk({tag, ".data"}, {24'd0, bd32}, {24'd0, d});
        chk({tag, ".last"}, {31'd0, last32}, {31'd0, last});
        chk({tag, ".rdy"},  {31'd0, rdy32},  {31'd0, rdy});
    endtask

    task automatic bus8(input string tag, input logic en, input logic [7:0] d,
                        input logic last, input logic rdy);
        chk({tag, ".en"},   {31'd0, en8},   {31'd0, en});
        if (en) chk({tag, ".data"}, {24'd0, bd8}, {24'd0, d});
        chk({tag, ".last"}, {31'd0, last8}, {31'd0, last});
        chk({tag, ".rdy"},  {31'd0, rdy8},  {31'd0, rdy});
    endtask

    initial begin
        // Reset state
        cyc();
        chk("rst.en",   {31'd0, en32},   32'd0);
        chk("rst.data", {24'd0, bd32},   32'd0);
        chk("rst.last", {31'd0, last32}, 32'd0);
        chk("rst.rdy",  {31'd0, rdy32},  32'd0);
        chk("rst.rdy8", {31'd0, rdy8},   32'd0);
        rst_n = 1'b1;
        #1 chk("rel.rdy", {31'd0, rdy32}, 32'd1);

        // Stall in IDLE is ignored
        cyc();
        st32 = 1'b1;
        #1 chk("idle_stall.rdy", {31'd0, rdy32}, 32'd1);
        st32 = 1'b0;

        // Single word, no stall
        v32 = 1'b1; d32 = 32'hDEADBEEF;
        cyc(); v32 = 1'b0;
        bus32("w1.b0", 1, 8'hEF, 0, 0);
        cyc(); bus32("w1.b1", 1, 8'hBE, 0, 0);
        cyc(); bus32("w1.b2", 1, 8'hAD, 0, 0);
        cyc(); bus32("w1.b3", 1, 8'hDE, 1, 1);
        cyc(); bus32("w1.end", 0, 8'h00, 0, 1);

        // Stall three cycles on AD: 7 bus cycles total
        v32 = 1'b1; d32 = 32'hDEADBEEF;
        cyc(); v32 = 1'b0;
        bus32("st.b0", 1, 8'hEF, 0, 0);
        cyc(); bus32("st.b1", 1, 8'hBE, 0, 0);
        cyc(); bus32("st.b2a", 1, 8'hAD, 0, 0); st32 = 1'b1;
        cyc(); bus32("st.b2b", 1, 8'hAD, 0, 0);
        cyc(); bus32("st.b2c", 1, 8'hAD, 0, 0);
        cyc(); bus32("st.b2d", 1, 8'hAD, 0, 0); st32 = 1'b0;
        cyc(); bus32("st.b3", 1, 8'hDE, 1, 1);
        cyc(); bus32("st.end", 0, 8'h00, 0, 1);

        // Back-to-back words, no gap
        v32 = 1'b1; d32 = 32'h03020100;
        cyc(); bus32("bb.b0", 1, 8'h00, 0, 0); d32 = 32'h07060504;
        cyc(); bus32("bb.b1", 1, 8'h01, 0, 0);
        cyc(); bus32("bb.b2", 1, 8'h02, 0, 0);
        cyc(); bus32("bb.b3", 1, 8'h03, 1, 1);
        cyc(); bus32("bb.b4", 1, 8'h04, 0, 0); v32 = 1'b0;
        cyc(); bus32("bb.b5", 1, 8'h05, 0, 0);
        cyc(); bus32("bb.b6", 1, 8'h06, 0, 0);
        cyc(); bus32("bb.b7", 1, 8'h07, 1, 1);
        cyc(); bus32("bb.end", 0, 8'h00, 0, 1);

        // Last byte stalled with next word waiting
        v32 = 1'b1; d32 = 32'hA3A2A1A0;
        cyc(); bus32("ls.b0", 1, 8'hA0, 0, 0); d32 = 32'hB3B2B1B0;
        cyc(); bus32("ls.b1", 1, 8'hA1, 0, 0);
        cyc(); bus32("ls.b2", 1, 8'hA2, 0, 0);
        cyc(); bus32("ls.b3", 1, 8'hA3, 1, 1); st32 = 1'b1;
        #1 chk("ls.stall_rdy", {31'd0, rdy32}, 32'd0);
        cyc(); bus32("ls.b3s", 1, 8'hA3, 1, 0); st32 = 1'b0;
        #1 chk("ls.unstall_rdy", {31'd0, rdy32}, 32'd1);
        cyc(); bus32("ls.n0", 1, 8'hB0, 0, 0); v32 = 1'b0;
        cyc(); bus32("ls.n1", 1, 8'hB1, 0, 0);
        cyc(); bus32("ls.n2", 1, 8'hB2, 0, 0);
        cyc(); bus32("ls.n3", 1, 8'hB3, 1, 1);
        cyc(); bus32("ls.end", 0, 8'h00, 0, 1);

        // Reset mid-word
        v32 = 1'b1; d32 = 32'h88776655;
        cyc(); bus32("rm.b0", 1, 8'h55, 0, 0); v32 = 1'b0;
        cyc(); bus32("rm.b1", 1, 8'h66, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("rm.en",   {31'd0, en32},   32'd0);
        chk("rm.data", {24'd0, bd32},   32'd0);
        chk("rm.last", {31'd0, last32}, 32'd0);
        chk("rm.rdy",  {31'd0, rdy32},  32'd0);
        cyc(); rst_n = 1'b1;
        #1 chk("rm.rel_rdy", {31'd0, rdy32}, 32'd1);
        cyc(); bus32("rm.idle", 0, 8'h00, 0, 1);
        chk("rm.idle_data", {24'd0, bd32}, 32'd0);
        cyc(); bus32("rm.idle2", 0, 8'h00, 0, 1);

        // WIDTH=8: one byte per cycle, every byte last
        v8 = 1'b1; d8 = 8'h11;
        #1 chk("w8.rdy0", {31'd0, rdy8}, 32'd1);
        cyc(); bus8("w8.b0", 1, 8'h11, 1, 1); d8 = 8'h22;
        cyc(); bus8("w8.b1", 1, 8'h22, 1, 1); d8 = 8'h33;
        cyc(); bus8("w8.b2", 1, 8'h33, 1, 1); v8 = 1'b0;
        cyc(); bus8("w8.end", 0, 8'h00, 0, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
